// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous, slow signal inside a
// fixed gate window of GATE_CYCLES clk cycles and reports the count with a
// one-cycle valid strobe. The counter saturates at all-ones and flags overflow.
// Optional feature macro FREQ_METER_AUTO_EN: after the first start, the meter
// re-arms itself and measures continuously (DONE -> GATE).
module freq_meter #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    // Gate counter only needs to hold GATE_CYCLES-1.
    localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              ovf_flag;

    logic              sync_s1;
    logic              sync_s2;
    logic              sync_s3;
    logic              sig_edge;

    // Edge counter saturates instead of wrapping; the caller sets the overflow flag.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}})
            return val;
        return val + CNT_W'(1);
    endfunction

    function automatic logic is_full(input logic [CNT_W-1:0] val);
        return (val == {CNT_W{1'b1}});
    endfunction

    // Two-flop synchroniser plus one delay flop for rising-edge detection; runs in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
            sync_s3 <= 1'b0;
        end else begin
            sync_s1 <= sig_in;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
        end
    end

    assign sig_edge = sync_s2 & ~sync_s3;

    // Measurement FSM: arm on start, count edges for the gate window, publish the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            valid    <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= GATE;
                        gate_cnt <= GATE_LOAD;
                        edge_cnt <= '0;
                        ovf_flag <= 1'b0;
                    end
                end
                GATE: begin
                    // An edge in the last gate cycle still counts.
                    if (sig_edge) begin
                        if (is_full(edge_cnt))
                            ovf_flag <= 1'b1;
                        else
                            edge_cnt <= sat_inc(edge_cnt);
                    end
                    if (gate_cnt == '0)
                        state <= DONE;
                    else
                        gate_cnt <= gate_cnt - GATE_W'(1);
                end
                DONE: begin
                    count    <= edge_cnt;
                    overflow <= ovf_flag;
                    valid    <= 1'b1;
`ifdef FREQ_METER_AUTO_EN
                    // Continuous mode: re-arm immediately, no return to IDLE.
                    state    <= GATE;
                    gate_cnt <= GATE_LOAD;
                    edge_cnt <= '0;
                    ovf_flag <= 1'b0;
`else
                    state    <= IDLE;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // busy is a pure decode of the registered state.
    assign busy = (state != IDLE);

endmodule
